// File: rtl/rand_range_pkg.sv
// rand_range_pkg
//   Shared definitions for the bounded random index block.
//   - RAND_W  : width of the random word produced by the LFSR generator.
//   - state_e : controller state encoding (IDLE, REDUCE, CHECK), 2 bits.
package rand_range_pkg;

   localparam int unsigned RAND_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      CHECK  = 2'd2
   } state_e;

endpackage : rand_range_pkg

// File: rtl/rand_mod_reduce.sv
// rand_mod_reduce
//   Load/subtract loop that reduces a random word into 0..RANGE-1 by
//   repeatedly subtracting RANGE, one subtraction per clock.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     start_i    : load data_i into the work register
//     data_i     : random word to reduce
//     run_i      : allow one subtraction this cycle (only if work >= RANGE)
//     work_o     : current work value
//     done_o     : work is already below RANGE (combinational)
module rand_mod_reduce
   import rand_range_pkg::*;
#(
   parameter int unsigned RANGE = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [RAND_W-1:0] data_i,
   input  logic              run_i,
   output logic [RAND_W-1:0] work_o,
   output logic              done_o
);

   localparam logic [RAND_W-1:0] RANGE_W = RAND_W'(RANGE);

   logic [RAND_W-1:0] work_q;
   logic [RAND_W-1:0] work_d;

   // Subtraction is gated by work >= RANGE, so the 8-bit result never wraps.
   always_comb begin
      work_d = work_q;
      if (start_i) begin
         work_d = data_i;
      end else if (run_i && (work_q >= RANGE_W)) begin
         work_d = work_q - RANGE_W;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
      end else begin
         work_q <= work_d;
      end
   end

   assign work_o = work_q;
   assign done_o = (work_q < RANGE_W);

endmodule : rand_mod_reduce

// File: rtl/rand_range.sv
// rand_range
//   Samples the free-running random byte on request, reduces it into
//   0..RANGE-1 and, with NO_REPEAT, bumps the result so two consecutive
//   results never match.
//   Handshake: req is sampled only while idle (busy=0); a request raised
//   while busy is dropped, not queued. valid is a one-cycle pulse marking
//   that value has just been updated; value holds until the next pulse.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     rand_in    : random byte from the LFSR generator
//     req        : request a new value
//     busy       : operation in flight (state != IDLE)
//     valid      : one-cycle pulse, value updated
//     value      : result 0..RANGE-1
module rand_range
   import rand_range_pkg::*;
#(
   parameter int unsigned RANGE     = 9,
   parameter bit          NO_REPEAT = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RAND_W-1:0] rand_in,
   input  logic              req,
   output logic              busy,
   output logic              valid,
   output logic [RAND_W-1:0] value
);

   if (RANGE < 1 || RANGE > 255) begin : g_bad_range
      $error("rand_range: RANGE must be within 1..255");
   end

   localparam logic [RAND_W-1:0] RANGE_M1 = RAND_W'(RANGE - 1);
   // With a single output value there is nothing to bump to.
   localparam bit BUMP_EN = NO_REPEAT && (RANGE > 1);

   state_e            state_q, state_d;
   logic [RAND_W-1:0] last_q, last_d;
   logic              have_prev_q, have_prev_d;
   logic [RAND_W-1:0] value_q, value_d;
   logic              valid_q, valid_d;

   logic              red_start;
   logic              red_run;
   logic [RAND_W-1:0] work;
   logic              red_done;
   logic [RAND_W-1:0] res;

   rand_mod_reduce #(
      .RANGE (RANGE)
   ) u_reduce (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (red_start),
      .data_i  (rand_in),
      .run_i   (red_run),
      .work_o  (work),
      .done_o  (red_done)
   );

   // Bump to the next value (wrapping to 0) when the raw result would repeat.
   always_comb begin
      res = work;
      if (BUMP_EN && have_prev_q && (work == last_q)) begin
         res = (work == RANGE_M1) ? '0 : work + 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      have_prev_d = have_prev_q;
      value_d     = value_q;
      valid_d     = 1'b0;
      red_start   = 1'b0;
      red_run     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               red_start = 1'b1;
               state_d   = REDUCE;
            end
         end
         REDUCE: begin
            red_run = 1'b1;
            if (red_done) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            value_d     = res;
            last_d      = res;
            have_prev_d = 1'b1;
            valid_d     = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= '0;
         have_prev_q <= 1'b0;
         value_q     <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         have_prev_q <= have_prev_d;
         value_q     <= value_d;
         valid_q     <= valid_d;
      end
   end

   assign busy  = (state_q != IDLE);
   assign valid = valid_q;
   assign value = value_q;

endmodule : rand_range
